// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, captured-request struct, misalignment helper.
package dmem_pkg;

   localparam int WORD_W = 32;   // data word and byte-address width
   localparam int LAT_W  = 4;    // wait-state counter width (LATENCY 0..15)
   localparam int BE_W   = 4;    // byte lanes per word

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } req_t;

   function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte-lane synchronous write and combinational read.
// Latency: write lands at the clock edge; read data reflects contents before that edge.
// Backpressure: none; the caller decides when to write and when to sample.
// Ports: clk, wr_en/wr_be/wr_data (lane-masked write), addr (word index), rd_data.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [BE_W-1:0]       wr_be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_W-1:0]     wr_data,
   output logic [WORD_W-1:0]     rd_data
);

   // Contents are deliberately not reset.
   logic [WORD_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      for (int k = 0; k < BE_W; k++) begin
         if (wr_en && wr_be[k]) begin
            mem[addr][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   // The responder samples this at the commit edge, so it sees the pre-edge word.
   assign rd_data = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time, LATENCY wait states.
// Latency: resp_valid rises the cycle after edge N+LATENCY (N = accept edge).
// Backpressure: response held stable until resp_ready; req_ready low from accept to response handshake.
// Ports: clk, rst (sync, active-high), req_valid/req_ready/req_write/req_addr/req_wdata,
//        resp_valid/resp_ready/resp_rdata/resp_err. Optional req_be when
//        DMEM_RESPONDER_BYTE_ENABLE_EN is defined (per-lane store masking).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_RESPONDER_BYTE_ENABLE_EN
   input  logic [BE_W-1:0]   req_be,
`endif
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   state_t                 state;
   state_t                 state_nxt;
   logic [LAT_W-1:0]       cnt;
   logic [LAT_W-1:0]       cnt_nxt;
   req_t                   req_in;
   req_t                   req_q;
   req_t                   req_cur;
   logic                   accept;
   logic                   commit;
   logic                   mis;
   logic                   arr_we;
   logic [ADDR_WIDTH-1:0]  word_idx;
   logic [WORD_W-1:0]      arr_rdata;
   logic                   unused_addr_hi;

   always_comb begin
      req_in       = '0;
      req_in.write = req_write;
      req_in.addr  = req_addr;
      req_in.wdata = req_wdata;
`ifdef DMEM_RESPONDER_BYTE_ENABLE_EN
      req_in.be    = req_be;
`else
      req_in.be    = '1;
`endif
   end

   assign accept = req_valid && req_ready;

   // With LATENCY=0 the commit happens on the accept edge itself, before the
   // request register is loaded, so the live inputs are used while IDLE.
   assign req_cur  = (state == IDLE) ? req_in : req_q;
   assign commit   = (state != RESP) && (state_nxt == RESP);
   assign mis      = is_misaligned(req_cur.addr);
   assign word_idx = req_cur.addr[ADDR_WIDTH+1:2];

   // Upper address bits alias by design.
   assign unused_addr_hi = ^req_cur.addr[WORD_W-1:ADDR_WIDTH+2];

   // A reset sampled on the commit edge cancels the store.
   assign arr_we = commit && req_cur.write && !mis && !rst;

   dmem_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .wr_en   (arr_we),
      .wr_be   (req_cur.be),
      .addr    (word_idx),
      .wr_data (req_cur.wdata),
      .rd_data (arr_rdata)
   );

   // State register plus request/response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         req_q      <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            req_q <= req_in;
         end
         if (commit) begin
            resp_rdata <= (req_cur.write || mis) ? '0 : arr_rdata;
            resp_err   <= mis;
         end
      end
   end

   // Next-state and wait counter.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = LAT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs.
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=0) against a word-array model.
// Latency: measured per transaction and compared with the instance's LATENCY.
// Backpressure: random resp_ready hold-off with stability checks on the held response.
module tb_dmem_responder;

   localparam int AW = 8;
`ifdef DMEM_RESPONDER_BYTE_ENABLE_EN
   localparam bit BE_EN = 1'b1;
`else
   localparam bit BE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic [3:0]  req_be     [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   logic [31:0] model [2][1<<AW];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dmem_responder #(
         .ADDR_WIDTH(AW),
         .LATENCY   ((g == 0) ? 2 : 0)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_write  (req_write[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
`ifdef DMEM_RESPONDER_BYTE_ENABLE_EN
         .req_be     (req_be[g]),
`endif
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction on instance d, starting and ending 1 time unit after a rising edge.
   task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold,
                         output logic [31:0] got);
      logic        mis;
      logic [31:0] idx;
      logic [31:0] exp_rd;
      int          waited;
      mis    = (addr[1:0] != 2'b00);
      idx    = 32'(addr[AW+1:2]);
      exp_rd = (wr || mis) ? 32'h0 : model[d][idx];
      chk("req_ready_idle", req_ready[d], 1);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      @(posedge clk); #1;
      // Scramble inputs after acceptance: the captured request must not follow them.
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'($urandom);
      if (wr && !mis) model[d][idx] = merge(model[d][idx], wdata, BE_EN ? be : 4'hf);
      waited = 0;
      while (resp_valid[d] !== 1'b1 && waited < 40) begin
         chk("req_ready_wait", req_ready[d], 0);
         @(posedge clk); #1;
         waited++;
      end
      chk("latency", waited, lat_of(d));
      chk("resp_rdata", resp_rdata[d], exp_rd);
      chk("resp_err", resp_err[d], mis);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", resp_valid[d], 1);
         chk("hold_rdata", resp_rdata[d], exp_rd);
         chk("hold_err", resp_err[d], mis);
         chk("hold_req_ready", req_ready[d], 0);
      end
      got = resp_rdata[d];
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      resp_ready[d] = 1'b0;
      chk("resp_done", resp_valid[d], 0);
      chk("req_ready_after", req_ready[d], 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      int          d;
      for (int i = 0; i < 2; i++) begin
         req_valid[i]  = 1'b0;
         req_write[i]  = 1'b0;
         req_addr[i]   = '0;
         req_wdata[i]  = '0;
         req_be[i]     = 4'hf;
         resp_ready[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_req_ready", req_ready[i], 1);
         chk("rst_resp_valid", resp_valid[i], 0);
         chk("rst_resp_rdata", resp_rdata[i], 0);
         chk("rst_resp_err", resp_err[i], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Fill both memories so every model word is known.
      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < (1 << AW); w++) begin
            do_txn(i, 1'b1, 32'(w) << 2, $urandom, 4'hf, 0, got);
         end
      end

      // Store then load on the LATENCY=2 instance.
      do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 0, got);
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'hf, 0, got);
      chk("t1_load", got, 32'hDEADBEEF);

      // Load held off by 5 cycles of resp_ready=0.
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'hf, 5, got);
      chk("t2_bp_load", got, 32'hDEADBEEF);

      // Misaligned store must not touch memory.
      do_txn(0, 1'b1, 32'h13, 32'h12345678, 4'hf, 1, got);
      chk("t3_mis_rdata", got, 32'h0);
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'hf, 0, got);
      chk("t3_load_unchanged", got, 32'hDEADBEEF);

      // Zero-latency instance: aliasing of upper address bits.
      do_txn(1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hf, 0, got);
      do_txn(1, 1'b0, 32'h000, 32'h0, 4'hf, 0, got);
      chk("t4_alias", got, 32'hCAFEF00D);

      // Reset during WAIT of a store: store lost.
      do_txn(0, 1'b1, 32'h20, 32'h0BADF00D, 4'hf, 0, got);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'hA5A5A5A5;
      req_be[0]    = 4'hf;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t5_rst_ready", req_ready[0], 1);
      chk("t5_rst_valid", resp_valid[0], 0);
      chk("t5_rst_rdata", resp_rdata[0], 0);
      rst = 1'b0;
      @(posedge clk); #1;
      do_txn(0, 1'b0, 32'h20, 32'h0, 4'hf, 0, got);
      chk("t5_load_old", got, 32'h0BADF00D);

`ifdef DMEM_RESPONDER_BYTE_ENABLE_EN
      do_txn(0, 1'b1, 32'h30, 32'h11223344, 4'hf, 0, got);
      do_txn(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 0, got);
      do_txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, got);
      chk("t6_be_merge", got, 32'h11BB33DD);
`endif

      // Random traffic on both instances.
      for (int n = 0; n < 300; n++) begin
         d = int'($urandom_range(0, 1));
         a = $urandom;
         a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         do_txn(d, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
